multicycle_controller: RTL and testbench

Moore FSM controller for the multi-cycle RV32I-subset datapath. It sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction and drives every mux select and write enable. It receives op/funct3/funct7/Zero/ALUResSign from the datapath and emits an InstrDone pulse per retired instruction.

---
 rtl/riscv_mc_pkg.sv | 113 +++++++++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/multicycle_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mc_pkg
// Shared definitions for the multi-cycle RV32I-subset controller.
//   - state_t       : controller FSM states
//   - OP_*          : supported major opcodes (Instr[6:0])
//   - ALU_*         : ALUControl codes driven to the datapath ALU
//   - IMM_*         : ImmSrc codes for the immediate extender
//   - RES_*         : ResultSrc codes for the result mux
//   - SRCA_*/SRCB_* : ALU operand mux selects
//   - ADR_*         : memory address mux selects
//   - ALUOP_*       : controller-to-alu_decoder operation class
//   - imm_src_of()  : immediate format from the opcode alone
//   - branch_taken(): branch condition from funct3 and ALU flags
// -----------------------------------------------------------------------------
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  // ALU operand A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Memory address mux
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Operation class handed to alu_decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // The immediate format depends only on the opcode, so the extender can be
  // driven in every state without consulting the FSM.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;   // lw, I-ALU, jalr and anything unsupported
    endcase
    return imm;
  endfunction

  // Branch condition evaluated on the rs1 - rs2 subtraction done in BRANCH.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       zero,
                                        input logic       sign);
    logic taken;
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;    // beq
      3'b001:  taken = !zero;   // bne
      3'b100:  taken = sign;    // blt
      3'b101:  taken = !sign;   // bge
      default: taken = 1'b0;    // unsupported branch kinds never redirect
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   alu_op      in  2  operation class from the controller FSM
//   funct3      in  3  Instr[14:12]
//   funct7b5    in  1  Instr[30]
//   opb5        in  1  op[5]: 1 for R-type, 0 for I-type ALU
//   alu_control out 3  ALU operation
// -----------------------------------------------------------------------------
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type honours funct7[5]; for addi that bit is part of the
          // immediate and must not turn the add into a subtract.
          3'b000:  alu_control = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing the multi-cycle RV32I-subset datapath
// (fetch / decode / execute / memory / writeback, 3-5 cycles per instruction).
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   op           in   Instr[6:0]
//   funct3       in   Instr[14:12]
//   funct7       in   Instr[31:25]
//   Zero         in   ALU result == 0
//   ALUResSign   in   ALU result bit 31
//   PCWrite      out  PC register load
//   AdrSrc       out  memory address select (0 PC, 1 Result)
//   MemWrite     out  data-memory write
//   IRWrite      out  IR / OldPC load
//   RegWrite     out  register-file write
//   ResultSrc    out  result mux select
//   ALUSrcA      out  ALU operand A select
//   ALUSrcB      out  ALU operand B select
//   ALUControl   out  ALU operation
//   ImmSrc       out  immediate format (from op only)
//   InstrDone    out  pulse in the last state of each instruction
//   Illegal      out  pulse in DECODE on an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResSign,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t     state_reg;
  state_t     state_next;

  // Ungated enables; the ports AND these with rst so nothing writes while
  // reset is held, even though the reset state (FETCH) would request writes.
  logic       pc_write_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic       instr_done_c;
  logic       illegal_c;
  logic [1:0] alu_op;

  // Only funct7[5] matters to the decode; the rest are carried on the port
  // for datapath symmetry.
  logic       unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = S_FETCH;
    pc_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    AdrSrc       = ADR_PC;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REG;
    alu_op       = ALUOP_ADD;

    case (state_reg)
      S_FETCH: begin
        // PC <= PC + 4 straight from the ALU while the IR captures the word.
        AdrSrc     = ADR_PC;
        ir_write_c = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        ResultSrc  = RES_ALURESULT;
        pc_write_c = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        // Precompute OldPC + imm so branch / jal already have their target
        // sitting in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR1;
          OP_LUI:            state_next = S_LUI;
          default: begin
            illegal_c  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        ResultSrc  = RES_ALUOUT;
        AdrSrc     = ADR_RESULT;
        state_next = S_MEMWB;
      end

      S_MEMWB: begin
        ResultSrc    = RES_MEMDATA;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end

      S_MEMWRITE: begin
        ResultSrc    = RES_ALUOUT;
        AdrSrc       = ADR_RESULT;
        mem_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end

      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_REG;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc    = RES_ALUOUT;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end

      S_BRANCH: begin
        // Compare rs1 - rs2 this cycle; the target computed in DECODE is in
        // ALUOut and is loaded into the PC only when the branch is taken.
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_REG;
        alu_op       = ALUOP_SUB;
        ResultSrc    = RES_ALUOUT;
        pc_write_c   = branch_taken(funct3, Zero, ALUResSign);
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end

      S_JAL: begin
        // PC <= ALUOut (target) while the ALU forms OldPC + 4 for the link
        // value, which ALUWB then writes into rd.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        ResultSrc  = RES_ALUOUT;
        pc_write_c = 1'b1;
        state_next = S_ALUWB;
      end

      S_JALR1: begin
        // Replace the DECODE-time target with rs1 + imm, then reuse JAL.
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = S_JAL;
      end

      S_LUI: begin
        ResultSrc    = RES_IMMEXT;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = S_FETCH;
      end

      default: begin
        // Unreachable encodings recover to FETCH without side effects.
        state_next = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7[5]),
    .opb5        (op[5]),
    .alu_control (ALUControl)
  );

  assign ImmSrc    = imm_src_of(op);

  assign PCWrite   = rst & pc_write_c;
  assign MemWrite  = rst & mem_write_c;
  assign IRWrite   = rst & ir_write_c;
  assign RegWrite  = rst & reg_write_c;
  assign InstrDone = rst & instr_done_c;
  assign Illegal   = rst & illegal_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench: each instruction is expanded into the list of
// per-cycle control words it should produce, and the DUT outputs are compared
// against that list cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       ALUResSign;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       InstrDone, Illegal;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .ALUResSign (ALUResSign),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .InstrDone  (InstrDone),
    .Illegal    (Illegal)
  );

  // One cycle's worth of controller outputs.
  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       done;
    logic       ill;
  } ctl_t;

  ctl_t obs_bus;
  assign obs_bus = '{pcw: PCWrite, adr: AdrSrc, memw: MemWrite, irw: IRWrite,
                     regw: RegWrite, rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB,
                     alu: ALUControl, imm: ImmSrc, done: InstrDone, ill: Illegal};

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) ||
           (o == JAL) || (o == JALR) || (o == LUI);
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] o);
    if (o == SW)  return 3'b001;
    if (o == BR)  return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI) return 3'b100;
    return 3'b000;
  endfunction

  // add / sub / and / or / slt for the ALU-class instructions
  function automatic logic [2:0] ref_alu(input bit is_r, input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'b000) return (is_r && f7[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b100;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic s);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return s;
    if (f3 == 3'b101) return !s;
    return 1'b0;
  endfunction

  function automatic ctl_t fetch_word(input logic [6:0] o);
    ctl_t c;
    c = '0;
    c.imm = ref_imm(o);
    c.pcw = 1'b1; c.irw = 1'b1; c.sb = 2'b10; c.rs = 2'b10;
    return c;
  endfunction

  // Drive one instruction and compare every cycle from FETCH to its last state.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic s);
    ctl_t q[$];
    ctl_t base, c;
    base = '0;
    base.imm = ref_imm(o);
    q.push_back(fetch_word(o));
    c = base; c.sa = 2'b01; c.sb = 2'b01; c.ill = !is_legal(o);
    q.push_back(c);
    if (o == LW || o == SW) begin
      c = base; c.sa = 2'b10; c.sb = 2'b01; q.push_back(c);
      if (o == LW) begin
        c = base; c.adr = 1'b1; q.push_back(c);
        c = base; c.rs = 2'b01; c.regw = 1'b1; c.done = 1'b1; q.push_back(c);
      end else begin
        c = base; c.adr = 1'b1; c.memw = 1'b1; c.done = 1'b1; q.push_back(c);
      end
    end else if (o == RT || o == IT) begin
      c = base; c.sa = 2'b10; c.sb = (o == IT) ? 2'b01 : 2'b00;
      c.alu = ref_alu(o == RT, f3, f7); q.push_back(c);
      c = base; c.regw = 1'b1; c.done = 1'b1; q.push_back(c);
    end else if (o == BR) begin
      c = base; c.sa = 2'b10; c.alu = 3'b001; c.done = 1'b1;
      c.pcw = ref_taken(f3, z, s); q.push_back(c);
    end else if (o == JAL || o == JALR) begin
      if (o == JALR) begin
        c = base; c.sa = 2'b10; c.sb = 2'b01; q.push_back(c);
      end
      c = base; c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; q.push_back(c);
      c = base; c.regw = 1'b1; c.done = 1'b1; q.push_back(c);
    end else if (o == LUI) begin
      c = base; c.rs = 2'b11; c.regw = 1'b1; c.done = 1'b1; q.push_back(c);
    end

    op = o; funct3 = f3; funct7 = f7; Zero = z; ALUResSign = s;
    foreach (q[k]) begin
      #2;
      check_eq($sformatf("%s#%0d cycle%0d", name, n_instr, k), 32'(obs_bus), 32'(q[k]));
      @(posedge clk); #1;
    end
    $display("instr %0d %s op=%b f3=%b f7=%b z=%b s=%b cycles=%0d",
             n_instr, name, o, f3, f7, z, s, q.size());
    n_instr++;
  endtask

  // Hold reset for n cycles, checking the FETCH word with all enables off.
  task automatic hold_reset(input string name, input int n);
    ctl_t c;
    rst = 1'b0;
    c = fetch_word(op);
    c.pcw = 1'b0; c.irw = 1'b0;
    for (int i = 0; i < n; i++) begin
      #2;
      check_eq($sformatf("%s cycle%0d", name, i), 32'(obs_bus), 32'(c));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    $display("reset %s held %0d cycles", name, n);
  endtask

  initial begin
    ctl_t c;
    logic [6:0] o;
    rst = 1'b0; op = LW; funct3 = 3'b010; funct7 = 7'd0; Zero = 1'b0; ALUResSign = 1'b0;
    #1;
    hold_reset("por", 2);

    // Directed instructions
    run_instr("lw",       LW,   3'b010, 7'b0000000, 1'b0, 1'b0);
    run_instr("sub",      RT,   3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr("add",      RT,   3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("addi_f7",  IT,   3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr("beq_t",    BR,   3'b000, 7'b0000000, 1'b1, 1'b0);
    run_instr("beq_nt",   BR,   3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("blt_t",    BR,   3'b100, 7'b0000000, 1'b0, 1'b1);
    run_instr("bge_nt",   BR,   3'b101, 7'b0000000, 1'b0, 1'b1);
    run_instr("bne_t",    BR,   3'b001, 7'b0000000, 1'b0, 1'b0);
    run_instr("br_f3_010",BR,   3'b010, 7'b0000000, 1'b1, 1'b1);
    run_instr("jal",      JAL,  3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("jalr",     JALR, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("illegal",  7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("lui",      LUI,  3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("sw",       SW,   3'b010, 7'b0000000, 1'b0, 1'b0);

    // Reset in the middle of lw (state MEMREAD), then a full lw again.
    op = LW; funct3 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    c = '0; c.adr = 1'b1; c.imm = 3'b000;
    check_eq("memread before reset", 32'(obs_bus), 32'(c));
    hold_reset("mid_lw", 3);
    run_instr("lw_after_rst", LW, 3'b010, 7'b0000000, 1'b0, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: o = LW;  1: o = SW;  2: o = RT;  3: o = IT;  4: o = BR;
        5: o = JAL; 6: o = JALR; 7: o = LUI;
        8: o = 7'b1111111;
        default: begin
          o = 7'($urandom_range(0, 127));
          if (is_legal(o)) o = 7'b0000000;
        end
      endcase
      run_instr("rand", o, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
